// File: rtl/act_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : act_share_arbiter_if
// Brief    : Requester, activation-unit and response signals of the shared
//            activation arbiter; master = requester/unit side, slave = arbiter.
// Revision : 1.0
// ============================================================================
interface act_share_arbiter_if #(
  parameter int BITWIDTH = 18,
  parameter int NREQ     = 4
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*BITWIDTH-1:0] req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     act_valid_o;
  logic [BITWIDTH-1:0]      act_data_o;
  logic [BITWIDTH-1:0]      act_res_i;
  logic [NREQ-1:0]          resp_valid;
  logic [BITWIDTH-1:0]      resp_data;
  logic                     busy;

  modport master (
    output req_valid, req_data, act_res_i,
    input  req_ready, act_valid_o, act_data_o, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_data, act_res_i,
    output req_ready, act_valid_o, act_data_o, resp_valid, resp_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/act_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : act_share_arbiter
// Brief    : Round-robin sharing of one fixed-latency activation unit among
//            NREQ requesters, with tag-tracked one-hot response routing.
// Revision : 1.0
// ============================================================================
module act_share_arbiter #(
  parameter int BITWIDTH = 18,
  parameter int NREQ     = 4,
  parameter int LATENCY  = 3,
  parameter int MAX_OUT  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  act_share_arbiter_if.slave bus
);
  localparam int c_tag_w = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_cnt_w = 3;
  localparam logic [c_cnt_w-1:0] c_max_out  = c_cnt_w'(MAX_OUT);
  localparam logic [c_tag_w-1:0] c_last_req = c_tag_w'(NREQ - 1);
  localparam logic [NREQ-1:0]    c_one      = NREQ'(1);

  logic [c_cnt_w-1:0]              r_cnt [NREQ];
  logic [c_tag_w-1:0]              r_ptr;
  logic                            r_act_valid;
  logic [BITWIDTH-1:0]             r_act_data;
  logic [LATENCY:0]                r_tag_v;
  logic [LATENCY:0][c_tag_w-1:0]   r_tag_id;
  logic [NREQ-1:0]                 r_resp_valid;
  logic [BITWIDTH-1:0]             r_resp_data;

  logic [NREQ-1:0]                 w_elig;
  logic [NREQ-1:0]                 w_grant;
  logic [NREQ-1:0]                 w_accept_vec;
  logic [c_tag_w-1:0]              w_grant_idx;
  logic                            w_found;
  logic                            w_accept;
  logic                            w_busy;
  int                              w_idx;

  for (genvar k = 0; k < NREQ; k++) begin : g_elig
    assign w_elig[k] = bus.req_valid[k] && (r_cnt[k] < c_max_out);
  end

  // Rotating search starting at r_ptr; first eligible requester wins.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && w_elig[w_idx[c_tag_w-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_idx[c_tag_w-1:0];
      end
    end
    w_grant[w_grant_idx] = w_found & rst_n;
  end

  assign w_accept_vec = bus.req_valid & w_grant;
  assign w_accept     = |w_accept_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_act_valid <= 1'b0;
      r_act_data  <= '0;
    end else begin
      r_act_valid <= w_accept;
      if (w_accept) begin
        r_act_data <= bus.req_data[int'(w_grant_idx) * BITWIDTH +: BITWIDTH];
        r_ptr      <= (w_grant_idx == c_last_req) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  // Tag stage LATENCY lines up with the unit result for the same operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v  <= {r_tag_v[LATENCY-1:0], w_accept};
      r_tag_id <= {r_tag_id[LATENCY-1:0], w_grant_idx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else if (r_tag_v[LATENCY]) begin
      r_resp_valid <= c_one << r_tag_id[LATENCY];
      r_resp_data  <= bus.act_res_i;
    end else begin
      r_resp_valid <= '0;
    end
  end

  // Accept and response for the same requester in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (w_accept_vec[k] && !r_resp_valid[k])
          r_cnt[k] <= r_cnt[k] + 1'b1;
        else if (!w_accept_vec[k] && r_resp_valid[k])
          r_cnt[k] <= r_cnt[k] - 1'b1;
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (r_cnt[k] != '0) w_busy = 1'b1;
  end

  assign bus.req_ready   = w_grant;
  assign bus.act_valid_o = r_act_valid;
  assign bus.act_data_o  = r_act_data;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_data   = r_resp_data;
  assign bus.busy        = w_busy;

  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_grant));
  a_resp_onehot  : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_resp_valid));

  for (genvar k = 0; k < NREQ; k++) begin : g_cnt_chk
    a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n) r_cnt[k] <= c_max_out);
  end
endmodule
`default_nettype wire
